request_sequencer: RTL and testbench

- Sequences instruction fetch and data access for the single-cycle MIPS datapath.
- Drives the memory request strobes iREN, dREN and dWEN.
- Generates pc_en for the program counter, so the PC advances exactly once per fully completed instruction.
- Provides a halt state, a retired-instruction counter and a memory-timeout watchdog.

---
 rtl/request_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_request_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/request_sequencer.sv
// request_sequencer: instruction/data request sequencing for the single-cycle
// MIPS datapath. Drives the memory strobes and gates PC advance so that the PC
// moves exactly once per completed instruction. Also provides a halt state, a
// saturating retired-instruction counter and a memory-wait watchdog.
module request_sequencer #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             ctr_dREN,
    input  logic             ctr_dWEN,
    input  logic             halt_in,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic             mem_timeout,
    output logic             dec_err
);

    typedef enum logic [1:0] {
        RSTW    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2,
        HALT    = 2'd3
    } state_t;

    // Watchdog thresholds. A TIMEOUT of 0 disables the flag entirely; the
    // wait counter then never leaves 0 because its hold value is 0.
    localparam logic             WD_EN     = (TIMEOUT > 0);
    localparam logic [TO_W-1:0]  WAIT_MAX  = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_reg;
    state_t            state_next;
    logic              iren_reg;
    logic              load_reg;
    logic              store_reg;
    logic              halted_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [TO_W-1:0]   wait_reg;
    logic              timeout_reg;
    logic              dec_err_reg;

    // Qualified events: ihit only matters in IFETCH, dhit only in DACCESS.
    logic fetch_hit;
    logic fetch_halt;
    logic fetch_mem;
    logic fetch_plain;
    logic fetch_wait;
    logic data_done;
    logic data_wait;
    logic waiting;
    logic moving;

    assign fetch_hit   = (state_reg == IFETCH) && ihit;
    assign fetch_halt  = fetch_hit && halt_in;
    assign fetch_mem   = fetch_hit && !halt_in && (ctr_dREN || ctr_dWEN);
    assign fetch_plain = fetch_hit && !halt_in && !ctr_dREN && !ctr_dWEN;
    assign fetch_wait  = (state_reg == IFETCH) && !ihit;
    assign data_done   = (state_reg == DACCESS) && dhit;
    assign data_wait   = (state_reg == DACCESS) && !dhit;
    assign waiting     = fetch_wait || data_wait;
    assign moving      = (state_next != state_reg);

    // Next-state selection; HALT outranks a memory access on the same fetch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RSTW:    state_next = IFETCH;
            IFETCH: begin
                if (fetch_halt) begin
                    state_next = HALT;
                end else if (fetch_mem) begin
                    state_next = DACCESS;
                end
            end
            DACCESS: begin
                if (dhit) begin
                    state_next = IFETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RSTW;
        endcase
    end

    // Sequencer state plus registered strobes: iREN tracks IFETCH, the load/store
    // latches drive dREN/dWEN for the whole data access, halted tracks HALT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= RSTW;
            iren_reg   <= 1'b0;
            load_reg   <= 1'b0;
            store_reg  <= 1'b0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            iren_reg   <= (state_next == IFETCH);
            halted_reg <= (state_next == HALT);
            case (state_reg)
                IFETCH: begin
                    if (fetch_mem) begin
                        // A conflicting decode is treated as a store.
                        store_reg <= ctr_dWEN;
                        load_reg  <= ctr_dREN && !ctr_dWEN;
                    end
                end
                DACCESS: begin
                    if (dhit) begin
                        store_reg <= 1'b0;
                        load_reg  <= 1'b0;
                    end
                end
                default: begin
                    store_reg <= 1'b0;
                    load_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Retired-instruction counter, saturating at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else if (pc_en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Wait counter: counts consecutive unsatisfied cycles in the current state
    // and holds once it reaches the threshold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_reg <= '0;
        end else if (moving || fetch_hit || data_done) begin
            wait_reg <= '0;
        end else if (waiting && (wait_reg != WAIT_MAX)) begin
            wait_reg <= wait_reg + TO_W'(1);
        end
    end

    // Sticky watchdog flag, set on the edge where the counter reaches TIMEOUT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout_reg <= 1'b0;
        end else if (WD_EN && waiting && (wait_reg == WAIT_LAST)) begin
            timeout_reg <= 1'b1;
        end
    end

    // Sticky decode-conflict flag: load and store both decoded on a fetch hit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dec_err_reg <= 1'b0;
        end else if (fetch_hit && ctr_dREN && ctr_dWEN) begin
            dec_err_reg <= 1'b1;
        end
    end

    // pc_en is combinational so the PC moves in the same cycle the
    // instruction completes; it can only fire in IFETCH or DACCESS.
    assign pc_en       = fetch_plain || data_done;
    assign iREN        = iren_reg;
    assign dREN        = load_reg;
    assign dWEN        = store_reg;
    assign halted      = halted_reg;
    assign instr_count = count_reg;
    assign mem_timeout = timeout_reg;
    assign dec_err     = dec_err_reg;

endmodule

// File: tb/tb_request_sequencer.sv
// tb_request_sequencer: randomized instruction-stream bench. The driver issues
// whole instructions (fetch latency, kind, data latency) and pushes the
// per-cycle expected outputs into a queue; a monitor pops and compares on the
// falling edge. Two instances share the stimulus: one with TIMEOUT=8 and a
// 4-bit counter (saturation), one with the watchdog disabled.
module tb_request_sequencer;

    localparam int TIMEOUT_M = 8;
    localparam int CNT_W_A   = 4;
    localparam int CNT_SAT_A = (1 << CNT_W_A) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic ihit = 1'b0;
    logic dhit = 1'b0;
    logic ctr_dREN = 1'b0;
    logic ctr_dWEN = 1'b0;
    logic halt_in = 1'b0;

    logic               a_iREN, a_dREN, a_dWEN, a_pc_en, a_halted, a_mem_timeout, a_dec_err;
    logic [CNT_W_A-1:0] a_instr_count;
    logic               b_iREN, b_dREN, b_dWEN, b_pc_en, b_halted, b_mem_timeout, b_dec_err;
    logic [31:0]        b_instr_count;

    request_sequencer #(.CNT_W(CNT_W_A), .TIMEOUT(TIMEOUT_M), .TO_W(16)) u_dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ctr_dREN(ctr_dREN), .ctr_dWEN(ctr_dWEN), .halt_in(halt_in),
        .iREN(a_iREN), .dREN(a_dREN), .dWEN(a_dWEN), .pc_en(a_pc_en),
        .halted(a_halted), .instr_count(a_instr_count),
        .mem_timeout(a_mem_timeout), .dec_err(a_dec_err)
    );

    request_sequencer #(.CNT_W(32), .TIMEOUT(0), .TO_W(16)) u_nowd (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .ctr_dREN(ctr_dREN), .ctr_dWEN(ctr_dWEN), .halt_in(halt_in),
        .iREN(b_iREN), .dREN(b_dREN), .dWEN(b_dWEN), .pc_en(b_pc_en),
        .halted(b_halted), .instr_count(b_instr_count),
        .mem_timeout(b_mem_timeout), .dec_err(b_dec_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        iren;
        logic        dren;
        logic        dwen;
        logic        pcen;
        logic        halted;
        logic        tout;
        logic        derr;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    // Instruction-level model state.
    int unsigned cnt_m    = 0;
    logic        to_m     = 1'b0;
    logic        de_m     = 1'b0;
    logic        halted_m = 1'b0;
    int          run_m    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic int lat();
        int r;
        r = int'($urandom_range(19, 0));
        if (r < 15) return r % 3;
        return int'($urandom_range(12, 5));
    endfunction

    task automatic model_reset();
        cnt_m    = 0;
        to_m     = 1'b0;
        de_m     = 1'b0;
        halted_m = 1'b0;
        run_m    = 0;
    endtask

    task automatic wd_wait();
        run_m++;
        if (run_m == TIMEOUT_M) to_m = 1'b1;
    endtask

    task automatic wd_hit();
        run_m = 0;
    endtask

    // One clock cycle: drive inputs just after the edge, queue expected outputs.
    task automatic drive_cycle(input logic r, input logic ih, input logic dh,
                               input logic cr, input logic cw, input logic hl,
                               input logic e_i, input logic e_r, input logic e_w,
                               input logic e_p);
        exp_t e;
        @(posedge CLK);
        #1;
        RST      = r;
        ihit     = ih;
        dhit     = dh;
        ctr_dREN = cr;
        ctr_dWEN = cw;
        halt_in  = hl;
        e.iren   = e_i;
        e.dren   = e_r;
        e.dwen   = e_w;
        e.pcen   = e_p;
        e.halted = halted_m;
        e.tout   = to_m;
        e.derr   = de_m;
        e.cnt    = cnt_m;
        exp_q.push_back(e);
    endtask

    // Two reset cycles, then the quiet cycle after release.
    task automatic reset_seq();
        model_reset();
        repeat (2) drive_cycle(1'b1, rb(), rb(), rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, rb(), rb(), rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // kind: 0 plain, 1 load, 2 store, 3 load+store conflict, 4 halt.
    task automatic run_instr(input int kind, input int ilat, input int dlat);
        logic ld, st, pc, last;
        for (int i = 0; i < ilat; i++) begin
            drive_cycle(1'b0, 1'b0, rb(), rb(), rb(), rb(), 1'b1, 1'b0, 1'b0, 1'b0);
            wd_wait();
        end
        ld = (kind == 1);
        st = (kind == 2) || (kind == 3);
        pc = (kind == 0);
        drive_cycle(1'b0, 1'b1, rb(), (kind == 1) || (kind == 3), st, (kind == 4),
                    1'b1, 1'b0, 1'b0, pc);
        wd_hit();
        if (pc) cnt_m++;
        if (kind == 3) de_m = 1'b1;
        if (kind == 4) halted_m = 1'b1;
        if (ld || st) begin
            for (int j = 0; j <= dlat; j++) begin
                last = (j == dlat);
                drive_cycle(1'b0, rb(), last, rb(), rb(), rb(), 1'b0, ld, st, last);
                if (last) begin
                    wd_hit();
                    cnt_m++;
                end else begin
                    wd_wait();
                end
            end
        end
        $display("instr kind=%0d ilat=%0d dlat=%0d retired=%0d", kind, ilat, dlat, cnt_m);
    endtask

    // HALT followed by 20 cycles of arbitrary inputs.
    task automatic halt_seq();
        run_instr(4, int'($urandom_range(2, 0)), 0);
        repeat (20) drive_cycle(1'b0, rb(), rb(), rb(), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Store interrupted by reset while waiting for dhit, with ihit/dhit held high.
    task automatic mid_reset_seq();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wd_hit();
        repeat (2) begin
            drive_cycle(1'b0, 1'b1, 1'b0, rb(), rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b0);
            wd_wait();
        end
        model_reset();
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("async_dWEN", {31'b0, a_dWEN}, 32'd0);
        chk("async_pc_en", {31'b0, a_pc_en}, 32'd0);
        chk("async_dWEN_nowd", {31'b0, b_dWEN}, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(0, 0, 0);
        $display("reset during data access done");
    endtask

    // Monitor: compare every queued expectation on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("iREN", {31'b0, a_iREN}, {31'b0, mon_e.iren});
                chk("dREN", {31'b0, a_dREN}, {31'b0, mon_e.dren});
                chk("dWEN", {31'b0, a_dWEN}, {31'b0, mon_e.dwen});
                chk("pc_en", {31'b0, a_pc_en}, {31'b0, mon_e.pcen});
                chk("halted", {31'b0, a_halted}, {31'b0, mon_e.halted});
                chk("mem_timeout", {31'b0, a_mem_timeout}, {31'b0, mon_e.tout});
                chk("dec_err", {31'b0, a_dec_err}, {31'b0, mon_e.derr});
                chk("instr_count_sat", {28'b0, a_instr_count},
                    (mon_e.cnt > 32'(CNT_SAT_A)) ? 32'(CNT_SAT_A) : mon_e.cnt);
                chk("nowd_iREN", {31'b0, b_iREN}, {31'b0, mon_e.iren});
                chk("nowd_dREN", {31'b0, b_dREN}, {31'b0, mon_e.dren});
                chk("nowd_dWEN", {31'b0, b_dWEN}, {31'b0, mon_e.dwen});
                chk("nowd_pc_en", {31'b0, b_pc_en}, {31'b0, mon_e.pcen});
                chk("nowd_halted", {31'b0, b_halted}, {31'b0, mon_e.halted});
                chk("nowd_mem_timeout", {31'b0, b_mem_timeout}, 32'd0);
                chk("nowd_dec_err", {31'b0, b_dec_err}, {31'b0, mon_e.derr});
                chk("nowd_instr_count", b_instr_count, mon_e.cnt);
            end
        end
    end

    // Stimulus: directed instruction sequences first, then random episodes.
    initial begin
        int n;
        reset_seq();
        for (int i = 0; i < 10; i++) run_instr(0, 0, 0);
        run_instr(1, 0, 2);
        run_instr(3, 1, 1);
        run_instr(0, 7, 0);
        run_instr(2, 0, 7);
        run_instr(0, 8, 0);
        run_instr(1, 0, 3);
        halt_seq();
        reset_seq();
        mid_reset_seq();
        for (int ep = 0; ep < 6; ep++) begin
            reset_seq();
            n = int'($urandom_range(60, 30));
            for (int k = 0; k < n; k++) begin
                run_instr(int'($urandom_range(3, 0)), lat(), lat());
            end
            if (ep % 2 == 0) halt_seq();
            else mid_reset_seq();
        end
        repeat (3) @(posedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
